bitinfo_reader: RTL and testbench

Initiator side of the bitinfo memory read port. On a start pulse, walks a bitinfo image held in a 1-cycle-latency synchronous memory (en/addr/dout). Checks the header, then streams every entry word out on a valid/ready interface, tagged with entry index and last flag. Used in benches and in the manager bring-up path to decode accelerator descriptors without a CPU.

---
 rtl/bitinfo_reader.sv | 205 ++++++++++++++++++++
 tb/tb_bitinfo_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitinfo_reader.sv
// bitinfo_reader: reads a bitinfo image from memory and streams its entries.
//
// On a start pulse the FSM walks a bitinfo image held in a synchronous memory
// with a one-cycle read latency. It checks the magic word, captures the version
// and entry count, and then streams every entry word on a valid/ready port.
//
// Image layout (word i at BASE_ADDR + 4*i):
//   w0 magic, w1 version, w2 entry count N, then N*ENTRY_WORDS entry words.
//
// Optional feature (macro BITINFO_CHECKSUM_EN): the image carries one extra
// word after the last entry. That word is the XOR of all preceding words, and
// it is read and checked before done is set.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             begin a walk (sampled only when idle)
//   busy              walk in progress
//   done, error       sticky status; both cleared by the next accepted start
//   err_code          0 none, 1 bad magic, 2 count too large, 3 checksum mismatch
//   version           captured w1
//   num_entries       captured w2[15:0]
//   mem_en, mem_addr  memory read request (byte address, word aligned)
//   mem_dout          memory read data, valid one cycle after mem_en
//   out_valid, out_ready, out_data, out_idx, out_last   entry word stream
module bitinfo_reader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter logic [31:0] MAGIC       = 32'h0BF1_B17F,
  parameter int unsigned ENTRY_WORDS = 4,
  parameter int unsigned MAX_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] version,
  output logic [15:0] num_entries,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [15:0] out_idx,
  output logic        out_last
);

  typedef enum logic [2:0] {StIdle, StReq, StCap, StEmit, StFin} state_e;

  localparam logic [4:0]  KLast = 5'(ENTRY_WORDS - 1);
  localparam logic [31:0] MaxN  = 32'(MAX_ENTRIES);

  state_e      state;
  logic [29:0] wcnt;   // word index of the read in flight
  logic [15:0] ent;    // entry index of the current entry word
  logic [4:0]  k;      // word index within the current entry
  logic [29:0] wnext;
  logic [31:0] next_addr;

`ifdef BITINFO_CHECKSUM_EN
  logic [31:0] xsum;      // running XOR of every word captured so far
  logic        ck_phase;  // the read in flight is the trailing checksum word
`endif

  assign wnext     = wcnt + 30'd1;
  assign next_addr = BASE_ADDR + {wnext, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      wcnt        <= '0;
      ent         <= '0;
      k           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'd0;
      version     <= '0;
      num_entries <= '0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
`ifdef BITINFO_CHECKSUM_EN
      xsum        <= '0;
      ck_phase    <= 1'b0;
`endif
    end else begin
      // mem_en is a single-cycle pulse issued on entry to StReq
      mem_en <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
            busy        <= 1'b1;
            version     <= '0;
            num_entries <= '0;
            wcnt        <= '0;
            ent         <= '0;
            k           <= '0;
            mem_en      <= 1'b1;
            mem_addr    <= BASE_ADDR;
            state       <= StReq;
`ifdef BITINFO_CHECKSUM_EN
            xsum        <= '0;
            ck_phase    <= 1'b0;
`endif
          end
        end

        StReq: state <= StCap;

        StCap: begin
`ifdef BITINFO_CHECKSUM_EN
          if (ck_phase) begin
            busy  <= 1'b0;
            state <= StIdle;
            if (mem_dout == xsum) begin
              done <= 1'b1;
            end else begin
              error    <= 1'b1;
              err_code <= 2'd3;
            end
          end else begin
            xsum <= xsum ^ mem_dout;
`endif
            if (wcnt == 30'd0 && mem_dout != MAGIC) begin
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'd1;
              state    <= StIdle;
            end else if (wcnt == 30'd2 && mem_dout > MaxN) begin
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'd2;
              state    <= StIdle;
            end else if (wcnt == 30'd2 && mem_dout == 32'd0) begin
              state <= StFin;
            end else if (wcnt < 30'd3) begin
              if (wcnt == 30'd1) version <= mem_dout;
              if (wcnt == 30'd2) num_entries <= mem_dout[15:0];
              wcnt     <= wnext;
              mem_addr <= next_addr;
              mem_en   <= 1'b1;
              state    <= StReq;
            end else begin
              out_data  <= mem_dout;
              out_idx   <= ent;
              out_last  <= (ent == num_entries - 16'd1) && (k == KLast);
              out_valid <= 1'b1;
              state     <= StEmit;
            end
`ifdef BITINFO_CHECKSUM_EN
          end
`endif
        end

        StEmit: begin
          // Next read is only issued once the current word is accepted
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state <= StFin;
            end else begin
              wcnt     <= wnext;
              mem_addr <= next_addr;
              mem_en   <= 1'b1;
              state    <= StReq;
              if (k == KLast) begin
                k   <= '0;
                ent <= ent + 16'd1;
              end else begin
                k <= k + 5'd1;
              end
            end
          end
        end

        StFin: begin
`ifdef BITINFO_CHECKSUM_EN
          // Checksum word sits directly after the last word consumed
          ck_phase <= 1'b1;
          wcnt     <= wnext;
          mem_addr <= next_addr;
          mem_en   <= 1'b1;
          state    <= StReq;
`else
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
`endif
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bitinfo_reader.sv
// Self-checking bench for bitinfo_reader: a table of images is walked with
// out_ready held high, followed by hand-written stall and reset sequences.
module tb_bitinfo_reader;

  localparam logic [31:0] MAGIC = 32'h0BF1_B17F;
`ifdef BITINFO_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] version;
  logic [15:0] num_entries;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_idx;
  logic        out_last;

  bitinfo_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .version    (version),
    .num_entries(num_entries),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency
  logic [31:0] mem [0:1023];
  always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr[11:2]];

  // Monitor: log every read request and every accepted beat
  logic [31:0] addr_q[$];
  logic [31:0] bdata_q[$];
  logic [15:0] bidx_q[$];
  logic        blast_q[$];
  always @(negedge clk) begin
    if (mem_en) addr_q.push_back(mem_addr);
    if (out_valid && out_ready) begin
      bdata_q.push_back(out_data);
      bidx_q.push_back(out_idx);
      blast_q.push_back(out_last);
    end
  end

  typedef struct {
    logic [31:0] w0;
    logic [31:0] cnt;
    logic [31:0] ckmask;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
    int          exp_reads;
    int          exp_beats;
    logic        hdr_ok;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] w0, input logic [31:0] cnt,
                         input logic [31:0] ckmask, input logic ed, input logic ee,
                         input logic [1:0] ec, input int er, input int eb, input logic h);
    vec_t v;
    v.w0 = w0; v.cnt = cnt; v.ckmask = ckmask;
    v.exp_done = ed; v.exp_err = ee; v.exp_code = ec;
    v.exp_reads = er; v.exp_beats = eb; v.hdr_ok = h;
    tbl.push_back(v);
  endtask

  task automatic load_image(input vec_t v);
    logic [31:0] x;
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = v.w0;
    mem[1] = 32'd1;
    mem[2] = v.cnt;
    if (v.cnt <= 32'd64) begin
      n = int'(v.cnt) * 4;
      for (int i = 0; i < n; i++) mem[3 + i] = 32'h10 + 32'(i);
      x = '0;
      for (int i = 0; i < 3 + n; i++) x = x ^ mem[i];
      mem[3 + n] = x ^ v.ckmask;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int cyc = 0;
    while (!(done || error) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_in_time"}, 32'(cyc < 5000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_stream(input string name, input vec_t v, input int a0, input int b0);
    int bad_a = 0;
    int bad_b = 0;
    int nr = addr_q.size() - a0;
    int nb = bdata_q.size() - b0;
    chk({name, "_done"}, 32'(done), 32'(v.exp_done));
    chk({name, "_error"}, 32'(error), 32'(v.exp_err));
    chk({name, "_err_code"}, 32'(err_code), 32'(v.exp_code));
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_reads"}, 32'(nr), 32'(v.exp_reads));
    chk({name, "_beats"}, 32'(nb), 32'(v.exp_beats));
    if (v.hdr_ok) begin
      chk({name, "_version"}, version, 32'd1);
      chk({name, "_num_entries"}, 32'(num_entries), 32'(v.cnt[15:0]));
    end
    for (int i = 0; i < nr; i++) if (addr_q[a0 + i] !== 32'(4 * i)) bad_a++;
    for (int i = 0; i < nb; i++) begin
      if (bdata_q[b0 + i] !== 32'h10 + 32'(i)) bad_b++;
      if (bidx_q[b0 + i] !== 16'(i / 4)) bad_b++;
      if (blast_q[b0 + i] !== (i == v.exp_beats - 1)) bad_b++;
    end
    chk({name, "_addr_seq"}, 32'(bad_a), 32'd0);
    chk({name, "_beat_content"}, 32'(bad_b), 32'd0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int a0, b0;
    load_image(v);
    a0 = addr_q.size();
    b0 = bdata_q.size();
    pulse_start();
    // One cycle after start was sampled: busy and first read request
    chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({name, "_first_mem_en"}, 32'(mem_en), 32'd1);
    chk({name, "_first_addr"}, mem_addr, 32'd0);
    wait_end(name);
    check_stream(name, v, a0, b0);
  endtask

  initial begin
    int a0, b0, cyc, bad;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    add_vec(MAGIC,         32'd2,  32'd0, 1'b1, 1'b0, 2'd0, 11 + CK,  8,   1'b1);
    add_vec(32'hDEADBEEF,  32'd2,  32'd0, 1'b0, 1'b1, 2'd1, 1,        0,   1'b0);
    add_vec(MAGIC,         32'd65, 32'd0, 1'b0, 1'b1, 2'd2, 3,        0,   1'b0);
    add_vec(MAGIC,         32'd0,  32'd0, 1'b1, 1'b0, 2'd0, 3 + CK,   0,   1'b1);
    add_vec(MAGIC,         32'd1,  32'd0, 1'b1, 1'b0, 2'd0, 7 + CK,   4,   1'b1);
    add_vec(MAGIC,         32'd64, 32'd0, 1'b1, 1'b0, 2'd0, 259 + CK, 256, 1'b1);
`ifdef BITINFO_CHECKSUM_EN
    add_vec(MAGIC,         32'd0,  32'h1,   1'b0, 1'b1, 2'd3, 4,  0, 1'b1);
    add_vec(MAGIC,         32'd2,  32'h100, 1'b0, 1'b1, 2'd3, 12, 8, 1'b1);
`endif

    repeat (3) @(negedge clk);
    chk("reset_outputs", {31'd0, busy | done | error | (|err_code) | (|version) |
        (|num_entries) | mem_en | (|mem_addr) | out_valid | (|out_data) |
        (|out_idx) | out_last}, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Stall five cycles on beat 3, with an ignored start during the stall
    load_image(tbl[0]);
    a0 = addr_q.size();
    b0 = bdata_q.size();
    pulse_start();
    cyc = 0;
    while (bdata_q.size() - b0 < 3 && cyc < 200) begin @(negedge clk); cyc++; end
    @(posedge clk); #1 out_ready = 1'b0;
    while (!out_valid && cyc < 200) begin @(negedge clk); cyc++; end
    chk("stall_reach_beat3", 32'(cyc < 200), 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || out_data !== 32'h13 || out_idx !== 16'd0 || out_last || mem_en) bad++;
      @(posedge clk); #1 start = (i == 1);
      @(negedge clk);
    end
    chk("stall_hold", 32'(bad), 32'd0);
    @(posedge clk); #1 out_ready = 1'b1; start = 1'b0;
    wait_end("stall");
    check_stream("stall", tbl[0], a0, b0);

    // Reset during an EMIT of entry 1, then a clean rerun
    load_image(tbl[0]);
    pulse_start();
    cyc = 0;
    while (!(out_valid && out_idx == 16'd1) && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reset_reach_entry1", 32'(cyc < 200), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midwalk_reset_outputs", {31'd0, busy | done | error | (|err_code) | (|version) |
        (|num_entries) | mem_en | (|mem_addr) | out_valid | (|out_data) |
        (|out_idx) | out_last}, 32'd0);
    @(negedge clk) rst = 1'b0;
    run_vec("after_reset", tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
